oddr_burst_sched: RTL and testbench
===================================

Name: oddr_burst_sched

Overview:
- Round-robin scheduler and gearbox that shares one ODDRXE-style 2:1 DDR output register among NREQ requesters.
- Grants one requester per burst, frames the burst with output-enable guard cycles, and serializes W-bit words into D0/D1 pairs, one pair per SCLK cycle.
- Sits in the SCLK domain directly in front of the DDR output primitive. D0, D1 and OE go straight to the primitive and pad tristate.

Parameters:
- NREQ, 2, number of requesters (1..8).
- W, 8, word width; even, 2..32.
- LW, 4, width of burst-length field; burst = LEN_M1+1 words.
- PRE_GUARD, 2, OE-high idle cycles before the first data pair (>=1).
- POST_GUARD, 1, OE-high idle cycles after the last data pair (>=0).
- IDLE_D0, 1'b0, D0 value on idle/guard cycles.
- IDLE_D1, 1'b0, D1 value on idle/guard cycles.

Ports:
- SCLK  in  1  clock; all logic is rising-edge.
- RSTB  in  1  reset, synchronous, active-high.
- REQ  in  NREQ  per-requester burst request; level, sampled only in IDLE.
- LEN_M1  in  NREQ*LW  packed per-requester burst length minus one; sampled with the grant.
- GNT  out  NREQ  one-hot grant, held for the whole burst including guards.
- DIN  in  NREQ*W  packed per-requester data word.
- DIN_VALID  in  NREQ  per-requester word valid.
- DIN_READY  out  NREQ  per-requester word accept; only the granted bit can be 1.
- D0  out  1  rising-edge DDR data to the primitive.
- D1  out  1  falling-edge DDR data to the primitive.
- OE  out  1  pad output enable.
- BUSY  out  1  high whenever state != IDLE.
- UNDERRUN  out  1  one-cycle pulse when a word slot passes with VALID low.

Behaviour:
- Reset (RSTB=1 at an edge): next cycle state=IDLE, GNT=0, DIN_READY=0, OE=0, D0/D1=IDLE_D0/IDLE_D1, BUSY=0, UNDERRUN=0, RR pointer=0. Reset mid-burst aborts the burst and emits no post-guard.
- D0, D1, OE, GNT, BUSY and UNDERRUN are registered. DIN_READY is combinational from state and counters, not from DIN_VALID.
- States are IDLE -> PRE -> DATA -> POST -> IDLE.
- IDLE: if any REQ bit is set at cycle G, choose the winner by round robin, searching upward from the pointer with wrap. Latch LEN_M1 of the winner. At G+1: GNT = winner, OE = 1, state = PRE. The pointer becomes winner+1 mod NREQ.
- PRE: lasts PRE_GUARD cycles and drives idle pairs. The final PRE cycle is the first word slot.
- Word slot: DIN_READY[winner] = 1. A handshake occurs when READY and VALID are both 1 in cycle T. Pairs then appear on D0/D1 in order {DIN[1],DIN[0]}, {DIN[3],DIN[2]}, ... at T+1 .. T+W/2: D0 = even bit, D1 = odd bit, LSB pair first. The next slot is cycle T+W/2, so back-to-back words are gap-free.
- Underrun: if VALID is 0 in a slot, the next cycle drives an idle pair with UNDERRUN = 1. The slot repeats every cycle until a handshake. The word count does not advance.
- The word counter counts handshakes. After handshake number LEN_M1+1, DIN_READY stays 0. Once the final pair has been output at cycle L, state = POST.
- POST: idle pairs with OE = 1 for POST_GUARD cycles (L+1 .. L+POST_GUARD). At L+POST_GUARD+1: OE = 0, GNT = 0, state = IDLE. With POST_GUARD = 0, OE drops at L+1.
- IDLE can re-arbitrate in its first cycle, so the minimum gap between bursts is 1 OE-low cycle.
- REQ changes during a burst are ignored. Dropping REQ does not abort a burst.
- LEN_M1 = all-ones gives 2^LW words. The word counter is LW+1 bits wide, with no wrap or truncation.
- Simultaneous REQ from all requesters: each requester is served exactly once per NREQ bursts.
- Invariant: OE = 0 implies D0/D1 are idle.

Test Plan:
- Single burst (NREQ=2, W=8, PRE=2, POST=1): REQ[0] at G, LEN_M1=1, VALID held high, words 8'hB4 and 8'h1E.
  - Required: GNT=01 and OE=1 at G+1; idle pairs at G+1..G+2; handshakes at G+2 and G+6.
  - D0/D1 sequence from G+3: (0,0), (1,0), (1,1), (0,1), (0,1), (1,1), (1,0), (0,0).
  - Then one idle pair with OE=1; OE=0 and GNT=00 at G+12.
- Round robin: REQ=11 held for 4 bursts of LEN_M1=0 -> GNT sequence 01, 10, 01, 10; each burst has 1 OE-low cycle between bursts.
- Underrun: VALID dropped for 3 cycles at the second slot -> 3 idle pairs with UNDERRUN=1 each; the second word is sent intact afterwards; total handshakes = LEN_M1+1.
- Max length: LEN_M1=4'hF -> exactly 16 handshakes and 64 data pairs; no early exit or wrap.
- Reset mid-DATA: RSTB=1 at cycle 5 of a burst -> next cycle OE=0, GNT=00, D0/D1 idle, BUSY=0; after release, REQ[1] alone is granted first (pointer=0, search wraps to 1).
- POST_GUARD=0 with a back-to-back REQ: OE falls at L+1, re-grant at L+2, exactly 1 OE-low cycle.

Source files
------------

// File: rtl/oddr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : oddr_burst_sched
// Purpose  : Round-robin burst scheduler and W:2 gearbox feeding a shared
//            ODDR-style output register, with OE guard framing.
// Revision : 1.0 - initial release
// ============================================================================
module oddr_burst_sched #(
   parameter int   NREQ       = 2,
   parameter int   W          = 8,
   parameter int   LW         = 4,
   parameter int   PRE_GUARD  = 2,
   parameter int   POST_GUARD = 1,
   parameter logic IDLE_D0    = 1'b0,
   parameter logic IDLE_D1    = 1'b0
) (
   input  logic               SCLK,
   input  logic               RSTB,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*LW-1:0] LEN_M1,
   output logic [NREQ-1:0]    GNT,
   input  logic [NREQ*W-1:0]  DIN,
   input  logic [NREQ-1:0]    DIN_VALID,
   output logic [NREQ-1:0]    DIN_READY,
   output logic               D0,
   output logic               D1,
   output logic               OE,
   output logic               BUSY,
   output logic               UNDERRUN
);

   localparam int c_IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_GW    = $clog2(PRE_GUARD + POST_GUARD + 1) + 1;
   localparam int c_NPAIR = W / 2;
   localparam int c_PW    = $clog2(c_NPAIR) + 1;
   localparam logic [c_GW-1:0] c_PRE_LAST  = c_GW'(PRE_GUARD - 1);
   localparam logic [c_GW-1:0] c_POST_LAST = c_GW'((POST_GUARD > 0) ? POST_GUARD - 1 : 0);
   localparam logic [c_PW-1:0] c_PAIR_LOAD = c_PW'(c_NPAIR - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_POST = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [c_IW-1:0]  r_ptr, w_ptr_nxt;
   logic [c_IW-1:0]  r_win, w_win_nxt;
   logic [LW-1:0]    r_len, w_len_nxt;
   logic [LW:0]      r_words, w_words_nxt;
   logic [c_GW-1:0]  r_cnt, w_cnt_nxt;
   logic [c_PW-1:0]  r_pairs, w_pairs_nxt;
   logic [W-1:0]     r_sh, w_sh_nxt;
   logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
   logic             r_oe, w_oe_nxt;
   logic             r_d0, w_d0_nxt;
   logic             r_d1, w_d1_nxt;
   logic             r_und, w_und_nxt;
   logic             r_busy;

   logic             w_any;
   logic [c_IW-1:0]  w_pick;
   logic             w_words_done;
   logic             w_slot;
   logic             w_valid;
   logic             w_hs;
   logic [W-1:0]     w_din;

   // Round-robin search upward from the pointer, wrapping; lowest offset wins.
   always_comb begin
      int idx;
      idx    = 0;
      w_any  = 1'b0;
      w_pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(r_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (REQ[idx]) begin
            w_any  = 1'b1;
            w_pick = c_IW'(idx);
         end
      end
   end

   assign w_words_done = (r_words == ({1'b0, r_len} + 1'b1));
   assign w_slot       = ((r_state == S_PRE  && r_cnt == c_PRE_LAST) ||
                          (r_state == S_DATA && r_pairs == '0)) && !w_words_done;
   assign w_valid      = DIN_VALID[r_win];
   assign w_din        = DIN[int'(r_win)*W +: W];
   assign w_hs         = w_slot && w_valid;
   assign DIN_READY    = w_slot ? r_gnt : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_win_nxt   = r_win;
      w_len_nxt   = r_len;
      w_words_nxt = r_words;
      w_cnt_nxt   = r_cnt;
      w_pairs_nxt = r_pairs;
      w_sh_nxt    = r_sh;
      w_gnt_nxt   = r_gnt;
      w_oe_nxt    = r_oe;
      w_d0_nxt    = IDLE_D0;
      w_d1_nxt    = IDLE_D1;
      w_und_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt       = S_PRE;
               w_win_nxt         = w_pick;
               w_ptr_nxt         = (int'(w_pick) == NREQ - 1) ? '0 : w_pick + 1'b1;
               w_len_nxt         = LEN_M1[int'(w_pick)*LW +: LW];
               w_words_nxt       = '0;
               w_cnt_nxt         = '0;
               w_pairs_nxt       = '0;
               w_gnt_nxt         = '0;
               w_gnt_nxt[w_pick] = 1'b1;
               w_oe_nxt          = 1'b1;
            end
         end
         S_PRE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_PRE_LAST) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            // Last pair of the last word is on the pins this cycle.
            if (r_pairs == '0 && w_words_done) begin
               w_cnt_nxt = '0;
               if (POST_GUARD == 0) begin
                  w_state_nxt = S_IDLE;
                  w_gnt_nxt   = '0;
                  w_oe_nxt    = 1'b0;
               end else begin
                  w_state_nxt = S_POST;
               end
            end
         end
         S_POST: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_POST_LAST) begin
               w_state_nxt = S_IDLE;
               w_gnt_nxt   = '0;
               w_oe_nxt    = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_hs) begin
         w_d0_nxt    = w_din[0];
         w_d1_nxt    = w_din[1];
         w_sh_nxt    = w_din >> 2;
         w_pairs_nxt = c_PAIR_LOAD;
         w_words_nxt = r_words + 1'b1;
      end else if (r_pairs != '0) begin
         w_d0_nxt    = r_sh[0];
         w_d1_nxt    = r_sh[1];
         w_sh_nxt    = r_sh >> 2;
         w_pairs_nxt = r_pairs - 1'b1;
      end else if (w_slot) begin
         w_und_nxt   = 1'b1;
      end
   end

   always_ff @(posedge SCLK) begin
      if (RSTB) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_len   <= '0;
         r_words <= '0;
         r_cnt   <= '0;
         r_pairs <= '0;
         r_sh    <= '0;
         r_gnt   <= '0;
         r_oe    <= 1'b0;
         r_d0    <= IDLE_D0;
         r_d1    <= IDLE_D1;
         r_und   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_win   <= w_win_nxt;
         r_len   <= w_len_nxt;
         r_words <= w_words_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pairs <= w_pairs_nxt;
         r_sh    <= w_sh_nxt;
         r_gnt   <= w_gnt_nxt;
         r_oe    <= w_oe_nxt;
         r_d0    <= w_d0_nxt;
         r_d1    <= w_d1_nxt;
         r_und   <= w_und_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   assign GNT      = r_gnt;
   assign OE       = r_oe;
   assign D0       = r_d0;
   assign D1       = r_d1;
   assign BUSY     = r_busy;
   assign UNDERRUN = r_und;

endmodule
`default_nettype wire

// File: tb/tb_oddr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_oddr_burst_sched
// Purpose  : Self-checking bench; per-burst expected traces are derived from
//            the burst timing rules (slot, gap, pair and guard offsets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oddr_burst_sched;

   localparam int NREQ      = 2;
   localparam int W         = 8;
   localparam int LW        = 4;
   localparam int PRE_GUARD = 2;
   localparam int c_NV      = 2*NREQ + 5;
   localparam int c_DW      = NREQ*W;
   localparam int c_LW      = NREQ*LW;

   logic               SCLK = 1'b0;
   logic               RSTB;
   logic [NREQ-1:0]    REQ;
   logic [c_LW-1:0]    LEN_M1;
   logic [c_DW-1:0]    DIN;
   logic [NREQ-1:0]    DIN_VALID;
   logic [NREQ-1:0]    gnt_a, gnt_b, rdy_a, rdy_b;
   logic               d0_a, d1_a, oe_a, busy_a, und_a;
   logic               d0_b, d1_b, oe_b, busy_b, und_b;
   logic               sel = 1'b0;
   logic [c_NV-1:0]    obs;

   int n_vec = 0;
   int n_err = 0;
   int mptr  = 0;
   logic [W-1:0] tw [16];
   int           tg [16];

   always #5 SCLK = ~SCLK;

   oddr_burst_sched #(.NREQ(NREQ), .W(W), .LW(LW), .PRE_GUARD(PRE_GUARD),
                      .POST_GUARD(1), .IDLE_D0(1'b0), .IDLE_D1(1'b0)) u_dut_a (
      .SCLK(SCLK), .RSTB(RSTB), .REQ(REQ), .LEN_M1(LEN_M1), .GNT(gnt_a),
      .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy_a), .D0(d0_a), .D1(d1_a),
      .OE(oe_a), .BUSY(busy_a), .UNDERRUN(und_a));

   oddr_burst_sched #(.NREQ(NREQ), .W(W), .LW(LW), .PRE_GUARD(PRE_GUARD),
                      .POST_GUARD(0), .IDLE_D0(1'b1), .IDLE_D1(1'b0)) u_dut_b (
      .SCLK(SCLK), .RSTB(RSTB), .REQ(REQ), .LEN_M1(LEN_M1), .GNT(gnt_b),
      .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy_b), .D0(d0_b), .D1(d1_b),
      .OE(oe_b), .BUSY(busy_b), .UNDERRUN(und_b));

   always_comb begin
      obs = sel ? {gnt_b, rdy_b, oe_b, busy_b, und_b, d0_b, d1_b}
                : {gnt_a, rdy_a, oe_a, busy_a, und_a, d0_a, d1_a};
   end

   // Instance a idles D0 low, instance b idles D0 high; D1 idles low on both.
   function automatic logic idle_d0();
      return sel;
   endfunction

   function automatic logic [c_NV-1:0] idle_vec();
      return {{(2*NREQ+3){1'b0}}, idle_d0(), 1'b0};
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] o, input logic [31:0] e);
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s @%0d observed=%h expected=%h", tag, idx, o, e);
      end
   endtask

   task automatic drive(input logic [NREQ-1:0] r, input int win, input logic [LW-1:0] len,
                        input logic v, input logic [W-1:0] wd, input bit set_len);
      REQ       = r;
      LEN_M1    = c_LW'($urandom);
      DIN       = c_DW'($urandom);
      DIN_VALID = NREQ'($urandom);
      if (win >= 0) begin
         DIN[win*W +: W] = wd;
         DIN_VALID[win]  = v;
         if (set_len) LEN_M1[win*LW +: LW] = len;
      end
   endtask

   task automatic do_reset();
      RSTB = 1'b1;
      drive('0, -1, '0, 1'b0, '0, 1'b0);
      repeat (3) @(negedge SCLK);
      chk("reset_state", 0, 32'(obs), 32'(idle_vec()));
      RSTB = 1'b0;
      mptr = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge SCLK);
         chk("idle", i, 32'(obs), 32'(idle_vec()));
         drive('0, -1, '0, 1'b0, '0, 1'b0);
      end
   endtask

   task automatic set_words(input int nw, input int gmax);
      for (int j = 0; j < nw; j++) begin
         tw[j] = W'($urandom);
         tg[j] = $urandom_range(0, gmax);
      end
   endtask

   // One burst from an idle DUT: offset 0 is the arbitration cycle G.
   task automatic run_burst(input logic [NREQ-1:0] reqm, input int nw, input int abort_at);
      logic [c_NV-1:0] ev  [512];
      logic            vld [512];
      logic [W-1:0]    wd  [512];
      logic [NREQ-1:0] oh;
      int win, s, t, e, postg, hs_obs, un_obs, un_exp, c;
      postg = sel ? 0 : 1;
      win = -1;
      for (int i = 0; i < NREQ; i++) begin
         c = (mptr + i) % NREQ;
         if (win < 0 && reqm[c]) win = c;
      end
      oh = '0;
      oh[win] = 1'b1;
      for (int k = 0; k < 512; k++) begin
         vld[k] = 1'($urandom);
         wd[k]  = W'($urandom);
         ev[k]  = {oh, {NREQ{1'b0}}, 3'b110, idle_d0(), 1'b0};
      end
      ev[0] = idle_vec();
      s = PRE_GUARD;
      un_exp = 0;
      for (int j = 0; j < nw; j++) begin
         for (int k = 0; k < tg[j]; k++) begin
            ev[s+k][5 +: NREQ] = oh;
            vld[s+k]           = 1'b0;
            ev[s+k+1][2]       = 1'b1;
            un_exp++;
         end
         t = s + tg[j];
         ev[t][5 +: NREQ] = oh;
         vld[t] = 1'b1;
         wd[t]  = tw[j];
         for (int p = 0; p < W/2; p++) begin
            ev[t+1+p][1] = tw[j][2*p];
            ev[t+1+p][0] = tw[j][2*p+1];
         end
         s = t + W/2;
      end
      e = s + postg + 1;
      mptr = (win + 1) % NREQ;

      hs_obs = 0;
      un_obs = 0;
      for (int off = 0; off < e; off++) begin
         @(negedge SCLK);
         chk("burst", off, 32'(obs), 32'(ev[off]));
         if (obs[5+win] && vld[off]) hs_obs++;
         if (obs[2]) un_obs++;
         drive((off == 0) ? reqm : NREQ'($urandom), win, LW'(nw - 1), vld[off], wd[off], off == 0);
         if (off == abort_at) begin
            RSTB = 1'b1;
            break;
         end
      end

      if (abort_at >= 0) begin
         @(negedge SCLK);
         chk("reset_abort", abort_at, 32'(obs), 32'(idle_vec()));
         RSTB = 1'b0;
         mptr = 0;
         drive('0, -1, '0, 1'b0, '0, 1'b0);
      end else begin
         chk("handshakes", win, 32'(hs_obs), 32'(nw));
         chk("underruns", win, 32'(un_obs), 32'(un_exp));
      end
   endtask

   initial begin
      logic [NREQ-1:0] rm;
      int nw;
      do_reset();
      idle_cycles(2);

      // Round robin with both requesting: 01, 10, 01, 10, back-to-back.
      for (int b = 0; b < 4; b++) begin
         set_words(1, 0);
         run_burst(2'b11, 1, -1);
      end
      idle_cycles(1);

      // Single burst of 8'hB4, 8'h1E with VALID held.
      tw[0] = 8'hB4; tw[1] = 8'h1E; tg[0] = 0; tg[1] = 0;
      run_burst(2'b01, 2, -1);
      idle_cycles(2);

      // Underrun of three cycles at the second slot.
      set_words(2, 0);
      tg[1] = 3;
      run_burst(2'b10, 2, -1);
      idle_cycles(1);

      // Maximum length: LEN_M1 all ones.
      set_words(16, 0);
      run_burst(2'b01, 16, -1);
      idle_cycles(1);

      // Reset mid-DATA, then a lone REQ[1] after release.
      set_words(4, 0);
      run_burst(2'b01, 4, 5);
      set_words(1, 0);
      run_burst(2'b10, 1, -1);
      idle_cycles(1);

      // Randomized bursts.
      for (int b = 0; b < 10; b++) begin
         rm = NREQ'($urandom_range(1, 3));
         nw = $urandom_range(1, 16);
         set_words(nw, 2);
         run_burst(rm, nw, -1);
         idle_cycles($urandom_range(0, 2));
      end

      // Zero post-guard instance, back-to-back bursts.
      sel = 1'b1;
      do_reset();
      idle_cycles(1);
      for (int b = 0; b < 6; b++) begin
         rm = (b < 3) ? 2'b11 : NREQ'($urandom_range(1, 3));
         nw = $urandom_range(1, 6);
         set_words(nw, 1);
         run_burst(rm, nw, -1);
      end
      idle_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
